data_mem_bhw: RTL and testbench

//  Parametrised data memory for the single-cycle/multi-cycle MIPS datapath.

---
 rtl/data_mem_bhw.sv | 168 ++++++++++++++++
 tb/tb_data_mem_bhw.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bhw.sv
// data_mem_bhw: byte/half/word data memory for the MIPS datapath.
// Requests use a valid/ready port. A request is accepted when req_valid is
// high while req_ready is high (FSM in IDLE). The response is a one-cycle
// rsp_valid pulse exactly LATENCY cycles after the acceptance cycle, and
// req_ready stays low until that pulse has finished.
// Stores write at the acceptance edge. Loads sample the word at the acceptance
// edge and hold the extended result until the response cycle.
module data_mem_bhw #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1,
    parameter int LOG_EN     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    // Cycles spent in WAIT before RESP; unused when LATENCY is 1.
    localparam logic [1:0] CNT_INIT = (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic [31:0] pend_data;
    logic        pend_err;

    // Higher address bits alias onto the same words.
    logic [ADDR_WIDTH-3:0] widx;
    logic [1:0]            lane;
    logic                  req_err;
    logic [31:0]           cur_word;
    logic [31:0]           wmask;
    logic [31:0]           wdata_rep;
    logic [31:0]           merged;
    logic [31:0]           byte_sh;
    logic [31:0]           half_sh;
    logic [31:0]           load_val;
    logic [31:0]           rsp_next;
    logic                  unused_bits;

    assign widx        = req_addr[ADDR_WIDTH-1:2];
    assign lane        = req_addr[1:0];
    assign dbg_state   = state;
    assign unused_bits = ^{req_addr[31:ADDR_WIDTH], req_pc};

    // Decode the request: error check, store merge, load extract and extend.
    always_comb begin
        req_err   = 1'b0;
        cur_word  = mem[widx];
        wmask     = 32'hFFFF_FFFF;
        wdata_rep = req_wdata;
        load_val  = cur_word;
        byte_sh   = cur_word >> {lane, 3'b000};
        half_sh   = cur_word >> {lane[1], 4'b0000};

        case (req_size)
            2'b00: begin
                wmask     = 32'h0000_00FF << {lane, 3'b000};
                wdata_rep = {4{req_wdata[7:0]}};
                load_val  = req_signed ? {{24{byte_sh[7]}}, byte_sh[7:0]}
                                       : {24'b0, byte_sh[7:0]};
            end
            2'b01: begin
                req_err   = lane[0];
                wmask     = 32'h0000_FFFF << {lane[1], 4'b0000};
                wdata_rep = {2{req_wdata[15:0]}};
                load_val  = req_signed ? {{16{half_sh[15]}}, half_sh[15:0]}
                                       : {16'b0, half_sh[15:0]};
            end
            2'b10: begin
                req_err = (lane != 2'b00);
            end
            default: begin
                req_err = 1'b1;
            end
        endcase

        merged   = (cur_word & ~wmask) | (wdata_rep & wmask);
        rsp_next = (req_we || req_err) ? 32'h0 : load_val;
    end

    // Request FSM, memory array and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            pend_data <= 32'h0;
            pend_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_we && !req_err) begin
                            mem[widx] <= merged;
                        end
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_next;
                            rsp_err   <= req_err;
                        end else begin
                            state     <= WAIT;
                            cnt       <= CNT_INIT;
                            pend_data <= rsp_next;
                            pend_err  <= req_err;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_data;
                        rsp_err   <= pend_err;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Store trace: one line per successful store, showing the merged word.
    always_ff @(posedge clk) begin
        if (!reset && LOG_EN != 0 && state == IDLE && req_valid && req_we && !req_err) begin
            $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, merged);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_bhw.sv
// tb_data_mem_bhw: drives two memories (LATENCY 1 and 3) with identical
// requests. A byte-array reference model predicts each response. Expected
// responses are queued together with the cycle they are due in, and one
// monitor per instance pops and compares them.
module tb_data_mem_bhw;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;

    logic        ready1, rv1, err1;
    logic [31:0] rd1;
    logic [1:0]  st1;
    logic        ready3, rv3, err3;
    logic [31:0] rd3;
    logic [1:0]  st3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Each entry holds {err, rdata, due cycle}.
    logic [64:0] q1[$];
    logic [64:0] q3[$];
    logic [7:0]  mbytes [0:4095];

    data_mem_bhw #(.ADDR_WIDTH(12), .LATENCY(1), .LOG_EN(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1), .dbg_state(st1)
    );

    data_mem_bhw #(.ADDR_WIDTH(12), .LATENCY(3), .LOG_EN(0)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3), .dbg_state(st3)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory as bytes, accesses as byte sequences.
    function automatic logic [32:0] model_access(input logic we, input logic [1:0] size,
                                                 input logic sgn, input logic [31:0] addr,
                                                 input logic [31:0] wdata);
        int nb;
        int base;
        logic err;
        logic [31:0] v;
        err  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base = int'(addr[11:0]);
        v    = 32'h0;
        if (err) return {1'b1, 32'h0};
        if (we) begin
            for (int k = 0; k < nb; k++) mbytes[base + k] = wdata[8*k +: 8];
            return {1'b0, 32'h0};
        end
        for (int k = 0; k < nb; k++) v = v | (32'(mbytes[base + k]) << (8 * k));
        if (sgn && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        return {1'b0, v};
    endfunction

    // Monitor for the LATENCY=1 instance.
    always @(negedge clk) begin
        logic [64:0] e;
        if (rv1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_rsp: rdata %h err %b at cycle %0d", rd1, err1, cyc);
            end else begin
                e = q1.pop_front();
                check("dut1_rdata", rd1, e[63:32]);
                check("dut1_err", {31'b0, err1}, {31'b0, e[64]});
                check("dut1_rsp_cycle", 32'(cyc), e[31:0]);
            end
        end
    end

    // Monitor for the LATENCY=3 instance.
    always @(negedge clk) begin
        logic [64:0] e;
        if (rv3 === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut3_unexpected_rsp: rdata %h err %b at cycle %0d", rd3, err3, cyc);
            end else begin
                e = q3.pop_front();
                check("dut3_rdata", rd3, e[63:32]);
                check("dut3_err", {31'b0, err3}, {31'b0, e[64]});
                check("dut3_rsp_cycle", 32'(cyc), e[31:0]);
            end
        end
    end

    // Waits (bounded) at negedges until both instances are ready.
    task automatic wait_ready();
        int guard = 0;
        while (!(ready1 === 1'b1 && ready3 === 1'b1) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: ready1 %b ready3 %b", ready1, ready3);
        end
    endtask

    // Issues one request to both instances and queues the expected responses.
    // If use_k is set, the expected rdata is the constant k.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic use_k, input logic [31:0] k);
        logic [32:0] r;
        int c0;
        wait_ready();
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_pc     = $urandom();
        c0 = cyc;
        r  = model_access(we, size, sgn, addr, wdata);
        if (use_k) r[31:0] = k;
        q1.push_back({r, 32'(c0 + 1)});
        q3.push_back({r, 32'(c0 + 3)});
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check("ready1_timing", {31'b0, ready1}, 32'(n > 1));
            check("ready3_timing", {31'b0, ready3}, 32'(n > 3));
            // While both are busy, present junk that must be ignored.
            if (ready1 === 1'b0 && ready3 === 1'b0) begin
                req_valid = 1'b1;
                req_we    = 1'($urandom_range(0, 1));
                req_size  = 2'($urandom_range(0, 3));
                req_addr  = $urandom_range(0, 63);
                req_wdata = $urandom();
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus.
    initial begin
        logic [32:0] r;
        int c0;
        for (int i = 0; i < 4096; i++) mbytes[i] = 8'h00;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_pc     = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_ready1", {31'b0, ready1}, 32'd1);
        check("reset_rv1", {31'b0, rv1}, 32'd0);
        check("reset_rdata1", rd1, 32'h0);
        check("reset_err1", {31'b0, err1}, 32'd0);
        check("reset_ready3", {31'b0, ready3}, 32'd1);
        check("reset_rv3", {31'b0, rv3}, 32'd0);
        check("reset_rdata3", rd3, 32'h0);
        check("reset_err3", {31'b0, err3}, 32'd0);

        // Directed sequence with known results.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 1'b1, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_5678);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 1'b1, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_AB78);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1, 32'hFFFF_FFAB);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0000_00AB);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, 1'b1, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 32'hFFFF_BEEF);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0000_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hBEEF_AB78);
        do_req(1'b1, 2'd2, 1'b0, 32'h13, 32'hDEAD_BEEF, 1'b1, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 1'b1, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hBEEF_AB78);
        do_req(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b1, 32'hBEEF_AB78);
        do_req(1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, 1'b1, 32'hBEEF_AB78);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0);

        // Reset while the LATENCY=3 instance is in WAIT: its response is dropped.
        wait_ready();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        c0 = cyc;
        r  = model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        q1.push_back({r, 32'(c0 + 1)});
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("rst_wait_ready3", {31'b0, ready3}, 32'd1);
        check("rst_wait_rv3", {31'b0, rv3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4096; i++) mbytes[i] = 8'h00;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0);

        // Random traffic over a small window with aliased upper address bits.
        for (int i = 0; i < 150; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom(),
                   1'b0, 32'h0);
        end

        repeat (6) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
